// File: rtl/mem_access_unit_pkg.sv
// mips_mem_pkg: shared encodings for the data-memory access path.
//   - access size codes (2'b11 is treated as a word everywhere)
//   - FSM state encoding for mem_access_unit
//   - latched request record and the alignment check
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_RD   = 2'd1,
    MA_WR   = 2'd2,
    MA_RESP = 2'd3
  } ma_state_e;

  // Fields captured on the accept edge; the bus is driven only from these.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ma_req_t;

  // Bytes are always aligned. Halfwords need addr[0]=0. Words, and the
  // reserved size code that behaves as a word, need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: bundles the MEM-stage request/response signals and the
// data-memory handshake of mem_access_unit.
//   slave  : view of the access unit (takes requests, drives memory)
//   master : view of the surroundings (pipeline + memory model)
// Signals:
//   req_valid/req_we/req_size/req_signed/req_addr/req_wdata : request
//   busy, rsp_valid, rsp_rdata, rsp_err                      : status/response
//   mRD, mWR, DataAddr, DataIn, DataOut                      : memory port
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        mRD;
  logic        mWR;
  logic [31:0] DataAddr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  DataOut,
    output busy, rsp_valid, rsp_rdata, rsp_err,
    output mRD, mWR, DataAddr, DataIn
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output DataOut,
    input  busy, rsp_valid, rsp_rdata, rsp_err,
    input  mRD, mWR, DataAddr, DataIn
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: purely combinational big-endian byte-lane logic.
//   i_offset : byte offset within the word (addr[1:0])
//   i_size   : access size code
//   i_signed : sign-extend loads when 1
//   i_rbuf   : word read from memory
//   i_wdata  : right-justified store data
//   o_merged : i_rbuf with the addressed lane(s) replaced by store data
//   o_load   : addressed lane right-justified and extended
// Lane k (offset k) lives in bits [31-8k -: 8], i.e. packed byte index 3-k.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_rbuf,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);

  logic [3:0][7:0] w_rbuf_b;
  logic [3:0][7:0] w_wdata_b;
  logic [3:0][7:0] w_merged_b;

  assign w_rbuf_b  = i_rbuf;
  assign w_wdata_b = i_wdata;
  assign o_merged  = w_merged_b;

  // Per-lane merge: each lane decides whether it is written and which store
  // byte lands on it; everything else passes rbuf through untouched.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    logic       w_hit;
    logic [7:0] w_byte;

    always_comb begin
      w_hit  = 1'b0;
      w_byte = 8'h00;
      case (i_size)
        SZ_BYTE: begin
          w_hit  = (i_offset == LANE);
          w_byte = w_wdata_b[0];
        end
        SZ_HALF: begin
          // Upper lane of the halfword takes wdata[15:8], lower takes [7:0].
          w_hit  = (i_offset[1] == LANE[1]);
          w_byte = LANE[0] ? w_wdata_b[0] : w_wdata_b[1];
        end
        default: begin
          w_hit  = 1'b1;
          w_byte = w_wdata_b[3-k];
        end
      endcase
    end

    assign w_merged_b[3-k] = w_hit ? w_byte : w_rbuf_b[3-k];
  end

  // Load extract.
  always_comb begin
    logic [7:0]  w_b;
    logic [15:0] w_h;
    w_b    = w_rbuf_b[2'd3 - i_offset];
    w_h    = i_offset[1] ? i_rbuf[15:0] : i_rbuf[31:16];
    o_load = i_rbuf;
    case (i_size)
      SZ_BYTE: o_load = {{24{i_signed & w_b[7]}}, w_b};
      SZ_HALF: o_load = {{16{i_signed & w_h[15]}}, w_h};
      default: o_load = i_rbuf;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store initiator for the word-indexed,
// big-endian 32-bit data memory. Sub-word stores are read-modify-write.
//   CLK : clock, rising edge active
//   RST : synchronous active-high reset
//   bus : mem_access_unit_if.slave (request, response, memory port)
// Flow: IDLE -> (RD) -> (WR) -> RESP -> IDLE. Misaligned requests go straight
// to RESP with rsp_err. Memory-port outputs are decoded from the registered
// state and latched request only, never from req_*.
module mem_access_unit
  import mips_mem_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  mem_access_unit_if.slave bus
);

  ma_state_e   r_state;
  ma_req_t     r_req;
  logic [31:0] r_rbuf;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic [31:0] w_src;
  logic [31:0] w_merged;
  logic [31:0] w_load;
  logic        w_in_rd;
  logic        w_in_wr;

  assign w_in_rd = (r_state == MA_RD);
  assign w_in_wr = (r_state == MA_WR);

  // During RD the load result is taken straight from DataOut so it can be
  // registered on the same edge that captures rbuf; in WR the merge works
  // from the captured rbuf.
  assign w_src = w_in_rd ? bus.DataOut : r_rbuf;

  mem_lane_align u_align (
    .i_offset (r_req.addr[1:0]),
    .i_size   (r_req.size),
    .i_signed (r_req.sgn),
    .i_rbuf   (w_src),
    .i_wdata  (r_req.wdata),
    .o_merged (w_merged),
    .o_load   (w_load)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= MA_IDLE;
      r_req       <= '0;
      r_rbuf      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      // Response fields are one-cycle pulses; only transitions into RESP
      // set them.
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        MA_IDLE: begin
          if (bus.req_valid) begin
            r_req <= '{we:    bus.req_we,
                       size:  bus.req_size,
                       sgn:   bus.req_signed,
                       addr:  bus.req_addr,
                       wdata: bus.req_wdata};
            if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
              r_state     <= MA_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (bus.req_we && bus.req_size[1]) begin
              r_state <= MA_WR;            // full word store: no read needed
            end else begin
              r_state <= MA_RD;            // loads and sub-word stores
            end
          end
        end
        MA_RD: begin
          r_rbuf <= bus.DataOut;
          if (r_req.we) begin
            r_state <= MA_WR;
          end else begin
            r_state     <= MA_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_load;
          end
        end
        MA_WR: begin
          r_state     <= MA_RESP;
          r_rsp_valid <= 1'b1;
        end
        default: r_state <= MA_IDLE;       // MA_RESP
      endcase
    end
  end

  assign bus.busy      = (r_state != MA_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;

  assign bus.mRD      = w_in_rd;
  // RST gates the write strobe directly so a reset cycle never writes.
  assign bus.mWR      = w_in_wr & ~RST;
  assign bus.DataAddr = (w_in_rd | w_in_wr) ? {2'b00, r_req.addr[31:2]} : 32'h0;
  assign bus.DataIn   = w_in_wr ? w_merged : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int vecs = 0;
  int errs = 0;

  // ---------------- memory model (DUT-facing) ----------------
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  assign bus.DataOut = bus.mRD ? mem[bus.DataAddr[5:0]] : 32'h0;

  always @(negedge clk)
    if (bus.mWR) mem[bus.DataAddr[5:0]] <= bus.DataIn;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          busy;
    bit          mrd;
    bit          mwr;
    logic [31:0] addr;
    logic [31:0] din;
    bit          rv;
    bit          err;
    logic [31:0] rdata;
  } cyc_t;

  function automatic cyc_t idle_c();
    cyc_t c;
    c.busy = 0; c.mrd = 0; c.mwr = 0; c.addr = 0; c.din = 0;
    c.rv = 0; c.err = 0; c.rdata = 0;
    return c;
  endfunction

  function automatic logic [31:0] m_extract(logic [31:0] w, int sz, int off, bit sgn);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * (3 - off))) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] m_merge(logic [31:0] w, int sz, int off, logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (sz == 0) begin
      sh = 8 * (3 - off); mask = 32'hFF;
    end else if (sz == 1) begin
      sh = (off >= 2) ? 0 : 16; mask = 32'hFFFF;
    end else return wd;
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  cyc_t plan[$];
  cyc_t exp_c;
  bit   have_exp  = 0;
  bit   last_busy = 0;

  always @(posedge clk) begin
    cyc_t cur, e;
    logic [31:0] a, wi, word;
    int sz, off;
    bit mis;
    cur = idle_c();
    if (rst) begin
      plan.delete();
    end else if (plan.size() > 0) begin
      cur = plan.pop_front();
    end else if (!last_busy && bus.req_valid) begin
      a    = bus.req_addr;
      wi   = a >> 2;
      off  = int'(a & 3);
      sz   = (bus.req_size == 2'b11) ? 2 : int'(bus.req_size);
      mis  = (sz == 1 && a[0]) || (sz == 2 && off != 0);
      word = ref_mem[wi[5:0]];
      if (!mis && (!bus.req_we || sz != 2)) begin
        e = idle_c(); e.busy = 1; e.mrd = 1; e.addr = wi;
        plan.push_back(e);
      end
      if (!mis && bus.req_we) begin
        e = idle_c(); e.busy = 1; e.mwr = 1; e.addr = wi;
        e.din = m_merge(word, sz, off, bus.req_wdata);
        plan.push_back(e);
      end
      e = idle_c(); e.busy = 1; e.rv = 1; e.err = mis;
      if (!mis && !bus.req_we) e.rdata = m_extract(word, sz, off, bus.req_signed);
      plan.push_back(e);
      cur = plan.pop_front();
    end
    last_busy = cur.busy;
    exp_c     = cur;
    have_exp  = 1;
  end

  // Single compare process: every cycle, all observable outputs.
  always @(negedge clk) begin
    bit emwr;
    if (have_exp) begin
      emwr = exp_c.mwr && !rst;
      vecs++;
      if (bus.busy !== exp_c.busy || bus.mRD !== exp_c.mrd || bus.mWR !== emwr ||
          bus.DataAddr !== exp_c.addr || bus.DataIn !== exp_c.din ||
          bus.rsp_valid !== exp_c.rv || bus.rsp_err !== exp_c.err ||
          bus.rsp_rdata !== exp_c.rdata) begin
        errs++;
        $display("FAIL cycle_cmp t=%0t got busy=%b rd=%b wr=%b addr=%h din=%h v=%b err=%b rdata=%h exp busy=%b rd=%b wr=%b addr=%h din=%h v=%b err=%b rdata=%h",
                 $time, bus.busy, bus.mRD, bus.mWR, bus.DataAddr, bus.DataIn, bus.rsp_valid,
                 bus.rsp_err, bus.rsp_rdata, exp_c.busy, exp_c.mrd, emwr, exp_c.addr,
                 exp_c.din, exp_c.rv, exp_c.err, exp_c.rdata);
      end
      if (emwr) ref_mem[exp_c.addr[5:0]] = exp_c.din;
    end
  end

  // ---------------- hand-computed checks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    vecs++;
    if (got !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic run(input string name, input bit we, input logic [1:0] size,
                     input bit sgn, input logic [31:0] addr, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_rd, input bit exp_err,
                     output logic [31:0] c1_addr, output bit c1_mrd,
                     output logic [31:0] din_seen);
    int lat;
    logic [31:0] rd;
    bit er;
    lat = 0; rd = 32'hX; er = 0; c1_addr = 0; c1_mrd = 0; din_seen = 0;
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_we = we; bus.req_size = size;
    bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin c1_addr = bus.DataAddr; c1_mrd = bus.mRD; end
      if (bus.mWR) din_seen = bus.DataIn;
      if (bus.rsp_valid) begin lat = c; rd = bus.rsp_rdata; er = bus.rsp_err; break; end
    end
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a1, din;
    bit m1;
    logic [8:0] mask;
    int rcount;

    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h1000_0000 + 32'(i);
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'h8123_4567; ref_mem[5] = 32'h8123_4567;

    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0;
    bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, bus.busy}, 32'h0);
    chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    @(posedge clk); #1 rst = 0;

    // word load
    run("ld_word", 0, 2'b10, 0, 32'h14, 0, 2, 32'h8123_4567, 0, a1, m1, din);
    chk("ld_word_c1_addr", a1, 32'h5);
    chk("ld_word_c1_mrd", {31'b0, m1}, 32'h1);
    // byte / halfword loads
    run("ld_sbyte", 0, 2'b00, 1, 32'h14, 0, 2, 32'hFFFF_FF81, 0, a1, m1, din);
    run("ld_ubyte", 0, 2'b00, 0, 32'h17, 0, 2, 32'h0000_0067, 0, a1, m1, din);
    run("ld_shalf_hi", 0, 2'b01, 1, 32'h14, 0, 2, 32'hFFFF_8123, 0, a1, m1, din);
    run("ld_shalf_lo", 0, 2'b01, 1, 32'h16, 0, 2, 32'h0000_4567, 0, a1, m1, din);
    // halfword store read-modify-write
    run("st_half", 1, 2'b01, 0, 32'h16, 32'h0000_BEEF, 3, 32'h0, 0, a1, m1, din);
    chk("st_half_din", din, 32'h8123_BEEF);
    run("ld_after_sth", 0, 2'b10, 0, 32'h14, 0, 2, 32'h8123_BEEF, 0, a1, m1, din);
    // misaligned
    run("mis_ldw", 0, 2'b10, 0, 32'h15, 0, 1, 32'h0, 1, a1, m1, din);
    run("mis_sth", 1, 2'b01, 0, 32'h13, 32'h1234, 1, 32'h0, 1, a1, m1, din);
    // word store, then size 11 load
    run("st_word", 1, 2'b10, 0, 32'h18, 32'hDEAD_BEEF, 2, 32'h0, 0, a1, m1, din);
    chk("st_word_din", din, 32'hDEAD_BEEF);
    run("ld_size3", 0, 2'b11, 0, 32'h18, 0, 2, 32'hDEAD_BEEF, 0, a1, m1, din);

    // reset during the WR cycle of a byte store
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'b00;
    bus.req_addr = 32'h19; bus.req_wdata = 32'h5A;
    @(posedge clk); #1 bus.req_valid = 0;   // cycle 1: RD
    @(posedge clk); #1 rst = 1;             // cycle 2: WR
    @(negedge clk);
    chk("rst_wr_mwr", {31'b0, bus.mWR}, 32'h0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_idle_busy", {31'b0, bus.busy}, 32'h0);
    rcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) rcount++;
    end
    chk("rst_no_rsp", 32'(rcount), 32'h0);
    chk("rst_mem_kept", mem[6], 32'hDEAD_BEEF);

    // reset and request together: request dropped
    @(posedge clk); #1;
    rst = 1; bus.req_valid = 1; bus.req_we = 0; bus.req_size = 2'b10; bus.req_addr = 32'h14;
    @(posedge clk); #1 rst = 0; bus.req_valid = 0;
    @(negedge clk);
    chk("rst_req_drop", {31'b0, bus.busy}, 32'h0);

    // busy: req_valid held with changing fields
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_we = 0; bus.req_size = 2'b10; bus.req_addr = 32'h14;
    @(posedge clk);                         // accept edge of A
    mask = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) mask[c] = 1'b1;
      if (c == 1) begin
        bus.req_we = 1; bus.req_size = 2'b10; bus.req_addr = 32'h20; bus.req_wdata = 32'h1234_5678;
      end
      if (c == 2) begin
        bus.req_we = 1; bus.req_size = 2'b00; bus.req_addr = 32'h10; bus.req_wdata = 32'h0000_00AA;
      end
      if (c == 4) bus.req_valid = 0;
    end
    chk("busy_rsp_cycles", {23'b0, mask}, 32'h044);
    run("ld_after_busy", 0, 2'b10, 0, 32'h10, 0, 2, 32'hAA00_0004, 0, a1, m1, din);
    run("ld_ignored", 0, 2'b10, 0, 32'h20, 0, 2, 32'h1000_0008, 0, a1, m1, din);

    // address wrap
    run("ld_wrap", 0, 2'b10, 0, 32'hFFFF_FFFC, 0, 2, 32'h1000_003F, 0, a1, m1, din);
    chk("ld_wrap_addr", a1, 32'h3FFF_FFFF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
